// File: rtl/soc_bus_pkg.sv
// Shared types and memory-map constants for the LSU-side bus bridge.
// Holds the size encodings, the bridge FSM states and the default two-slave decode map.
package soc_bus_pkg;

   typedef enum logic [2:0] {
      RW_B  = 3'b000,
      RW_H  = 3'b001,
      RW_W  = 3'b010,
      RW_BU = 3'b100,
      RW_HU = 3'b101
   } rwtyp_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } bridge_state_e;

   // Default map: slot 0 = 0x0xxx_xxxx, slot 1 = 0x1xxx_xxxx
   localparam logic [63:0] DEF_SLV_BASE = {32'h1000_0000, 32'h0000_0000};
   localparam logic [63:0] DEF_SLV_MASK = {32'hF000_0000, 32'hF000_0000};

   localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

   function automatic logic rwtyp_legal(input logic [2:0] typ);
      case (typ)
         RW_B, RW_H, RW_W, RW_BU, RW_HU: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_addr_dec.sv
// Combinational address decoder: one-hot slave select (lowest index wins),
// plus a misalignment flag for halfword and word accesses.
module lsu_addr_dec
   import soc_bus_pkg::*;
#(
   parameter int                   N_SLV    = 2,
   parameter logic [N_SLV*32-1:0]  SLV_BASE = DEF_SLV_BASE,
   parameter logic [N_SLV*32-1:0]  SLV_MASK = DEF_SLV_MASK
)(
   input  logic [31:0]      addr,
   input  logic [2:0]       rwtyp,
   output logic [N_SLV-1:0] sel,
   output logic             hit,
   output logic             misalign
);

   always_comb begin
      sel = '0;
      hit = 1'b0;
      for (int i = 0; i < N_SLV; i++) begin
         if (!hit && ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
            sel[i] = 1'b1;
            hit    = 1'b1;
         end
      end
   end

   always_comb begin
      misalign = 1'b0;
      case (rwtyp)
         RW_H, RW_HU: misalign = addr[0];
         RW_W:        misalign = |addr[1:0];
         default:     misalign = 1'b0;
      endcase
   end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Routes single-outstanding LSU requests to one of N_SLV slave ports by address,
// answering unmapped, misaligned, illegal-size and timed-out accesses with an error.
module lsu_bus_bridge
   import soc_bus_pkg::*;
#(
   parameter int                   N_SLV    = 2,
   parameter logic [N_SLV*32-1:0]  SLV_BASE = DEF_SLV_BASE,
   parameter logic [N_SLV*32-1:0]  SLV_MASK = DEF_SLV_MASK,
   parameter int unsigned          TIMEOUT  = 255
)(
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  lsu_req_vld,
   output logic                  lsu_req_rdy,
   input  logic                  lsu_wen,
   input  logic [2:0]            lsu_rwtyp,
   input  logic [31:0]           lsu_addr,
   input  logic [31:0]           lsu_wdata,
   output logic                  lsu_rsp_vld,
   input  logic                  lsu_rsp_rdy,
   output logic [31:0]           lsu_rsp_rdata,
   output logic                  lsu_rsp_err,

   output logic [N_SLV-1:0]      s_req_vld,
   input  logic [N_SLV-1:0]      s_req_rdy,
   output logic                  s_wen,
   output logic [2:0]            s_rwtyp,
   output logic [31:0]           s_addr,
   output logic [31:0]           s_wdata,
   input  logic [N_SLV-1:0]      s_rsp_vld,
   input  logic [N_SLV*32-1:0]   s_rsp_rdata,
   output logic [N_SLV-1:0]      s_rsp_rdy
);

   localparam int CNT_BITS = $clog2(64'(TIMEOUT) + 64'd1);
   localparam int CNT_W    = (CNT_BITS < 8) ? 8 : ((CNT_BITS > 32) ? 32 : CNT_BITS);

   bridge_state_e      state_q, state_d;
   logic [N_SLV-1:0]   sel_q;
   logic [N_SLV-1:0]   dec_sel;
   logic               dec_hit;
   logic               dec_misalign;
   logic               req_bad;
   logic [31:0]        sel_rdata;
   logic [31:0]        rsp_rdata_q;
   logic               rsp_err_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               timeout_hit;
   logic               accept;
   logic               capture;
   logic               tmo;
   logic               cnt_clr;

   lsu_addr_dec #(
      .N_SLV    (N_SLV),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .addr     (lsu_addr),
      .rwtyp    (lsu_rwtyp),
      .sel      (dec_sel),
      .hit      (dec_hit),
      .misalign (dec_misalign)
   );

   assign req_bad     = !dec_hit || dec_misalign || !rwtyp_legal(lsu_rwtyp);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (sel_q[i]) sel_rdata = sel_rdata | s_rsp_rdata[32*i +: 32];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Slave handshakes only look at the selected lane, so strays from others are dropped
   always_comb begin
      state_d     = state_q;
      lsu_req_rdy = 1'b0;
      lsu_rsp_vld = 1'b0;
      s_req_vld   = '0;
      s_rsp_rdy   = '0;
      accept      = 1'b0;
      capture     = 1'b0;
      tmo         = 1'b0;
      cnt_clr     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            lsu_req_rdy = 1'b1;
            if (lsu_req_vld) begin
               accept  = 1'b1;
               cnt_clr = 1'b1;
               state_d = req_bad ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            s_req_vld = sel_q;
            if (|(s_req_rdy & sel_q)) begin
               cnt_clr = 1'b1;
               state_d = ST_WAIT;
            end else if (timeout_hit) begin
               tmo     = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_WAIT: begin
            s_rsp_rdy = sel_q;
            if (|(s_rsp_vld & sel_q)) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               tmo     = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            lsu_rsp_vld = 1'b1;
            if (lsu_rsp_rdy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_wen       <= 1'b0;
         s_rwtyp     <= 3'b000;
         s_addr      <= 32'h0;
         s_wdata     <= 32'h0;
         sel_q       <= '0;
         rsp_rdata_q <= ERR_RDATA;
         rsp_err_q   <= 1'b0;
      end else if (accept) begin
         s_wen       <= lsu_wen;
         s_rwtyp     <= lsu_rwtyp;
         s_addr      <= lsu_addr;
         s_wdata     <= lsu_wdata;
         sel_q       <= req_bad ? '0 : dec_sel;
         rsp_rdata_q <= ERR_RDATA;
         rsp_err_q   <= req_bad;
      end else if (capture) begin
         rsp_rdata_q <= s_wen ? ERR_RDATA : sel_rdata;
         rsp_err_q   <= 1'b0;
      end else if (tmo) begin
         rsp_rdata_q <= ERR_RDATA;
         rsp_err_q   <= 1'b1;
      end
   end

   // Timeout counter restarts on each entry into ISSUE and WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                           cnt_q <= '0;
      else if (cnt_clr)                                  cnt_q <= '0;
      else if (state_q == ST_ISSUE || state_q == ST_WAIT) cnt_q <= cnt_q + CNT_W'(1);
   end

   assign lsu_rsp_rdata = rsp_rdata_q;
   assign lsu_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: a reactive slave model plus a response scoreboard.
// Latencies count clock edges from the request-accept edge (that edge counts as 1).
module tb_lsu_bus_bridge;
   import soc_bus_pkg::*;

   localparam int N_SLV = 2;
   localparam int TMO   = 8;

   logic                 clk;
   logic                 rst;
   logic                 lsu_req_vld;
   logic                 lsu_req_rdy;
   logic                 lsu_wen;
   logic [2:0]           lsu_rwtyp;
   logic [31:0]          lsu_addr;
   logic [31:0]          lsu_wdata;
   logic                 lsu_rsp_vld;
   logic                 lsu_rsp_rdy;
   logic [31:0]          lsu_rsp_rdata;
   logic                 lsu_rsp_err;
   logic [N_SLV-1:0]     s_req_vld;
   logic [N_SLV-1:0]     s_req_rdy;
   logic                 s_wen;
   logic [2:0]           s_rwtyp;
   logic [31:0]          s_addr;
   logic [31:0]          s_wdata;
   logic [N_SLV-1:0]     s_rsp_vld;
   logic [N_SLV*32-1:0]  s_rsp_rdata;
   logic [N_SLV-1:0]     s_rsp_rdy;

   lsu_bus_bridge #(
      .N_SLV    (N_SLV),
      .SLV_BASE (DEF_SLV_BASE),
      .SLV_MASK (DEF_SLV_MASK),
      .TIMEOUT  (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .lsu_req_vld   (lsu_req_vld),
      .lsu_req_rdy   (lsu_req_rdy),
      .lsu_wen       (lsu_wen),
      .lsu_rwtyp     (lsu_rwtyp),
      .lsu_addr      (lsu_addr),
      .lsu_wdata     (lsu_wdata),
      .lsu_rsp_vld   (lsu_rsp_vld),
      .lsu_rsp_rdy   (lsu_rsp_rdy),
      .lsu_rsp_rdata (lsu_rsp_rdata),
      .lsu_rsp_err   (lsu_rsp_err),
      .s_req_vld     (s_req_vld),
      .s_req_rdy     (s_req_rdy),
      .s_wen         (s_wen),
      .s_rwtyp       (s_rwtyp),
      .s_addr        (s_addr),
      .s_wdata       (s_wdata),
      .s_rsp_vld     (s_rsp_vld),
      .s_rsp_rdata   (s_rsp_rdata),
      .s_rsp_rdy     (s_rsp_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          slv_lat     = 1;
   logic [31:0] slv_rdata   = 32'h0;
   int          pulse_req   = 0;
   int          req_count   = 0;
   logic [1:0]  last_req_vld = 2'b00;

   // Slave model: always ready, answers slv_lat cycles after the request handshake (0 = never)
   initial begin : slave_model
      int cnt;
      int rsp_idx;
      int pulse_done;
      bit req_hs;
      bit rsp_hs;
      bit pulse_on;
      cnt = 0; rsp_idx = 0; pulse_done = 0;
      req_hs = 1'b0; rsp_hs = 1'b0; pulse_on = 1'b0;
      s_req_rdy   = '0;
      s_rsp_vld   = '0;
      s_rsp_rdata = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
      forever begin
         @(negedge clk);
         if (rst) begin
            s_req_rdy = '0;
            s_rsp_vld = '0;
            cnt = 0; req_hs = 1'b0; rsp_hs = 1'b0; pulse_on = 1'b0;
         end else begin
            if (rsp_hs || pulse_on) begin
               s_rsp_vld = '0;
               pulse_on  = 1'b0;
            end
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  s_rsp_rdata = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
                  s_rsp_vld[rsp_idx] = 1'b1;
                  s_rsp_rdata[32*rsp_idx +: 32] = slv_rdata;
               end
            end
            if (req_hs) cnt = slv_lat;
            if (pulse_req != pulse_done) begin
               s_rsp_vld[0] = 1'b1;
               pulse_on     = 1'b1;
               pulse_done   = pulse_req;
            end
            s_req_rdy = s_req_vld;
            if (|s_req_vld) rsp_idx = s_req_vld[1] ? 1 : 0;
            req_hs = |(s_req_vld & s_req_rdy);
            if (req_hs) begin
               req_count++;
               last_req_vld = s_req_vld;
            end
            rsp_hs = |(s_rsp_vld & s_rsp_rdy);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic wen, input logic [2:0] typ, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_lat);
      exp_t e;
      compare("req_rdy_idle", 32'(lsu_req_rdy), 32'd1);
      lsu_req_vld = 1'b1;
      lsu_wen     = wen;
      lsu_rwtyp   = typ;
      lsu_addr    = addr;
      lsu_wdata   = wdata;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = exp_lat;
      sb.push_back(e);
      tick();
      lsu_req_vld = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input int hold);
      exp_t e;
      int   n;
      n = 1;
      while (!lsu_rsp_vld && n < 40) begin
         tick();
         n++;
      end
      vectors++;
      assert (sb.size() > 0) else begin
         miscompares++;
         $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         compare({tag, "_rsp_vld"}, 32'(lsu_rsp_vld), 32'd1);
         compare({tag, "_latency"}, 32'(n), 32'(e.lat));
         compare({tag, "_rdata"}, lsu_rsp_rdata, e.rdata);
         compare({tag, "_err"}, 32'(lsu_rsp_err), 32'(e.err));
         compare({tag, "_s_req_vld_off"}, 32'(s_req_vld), 32'd0);
         compare({tag, "_s_rsp_rdy_off"}, 32'(s_rsp_rdy), 32'd0);
         for (int i = 0; i < hold; i++) begin
            compare({tag, "_hold_req_rdy"}, 32'(lsu_req_rdy), 32'd0);
            tick();
            compare({tag, "_hold_vld"}, 32'(lsu_rsp_vld), 32'd1);
            compare({tag, "_hold_rdata"}, lsu_rsp_rdata, e.rdata);
            compare({tag, "_hold_err"}, 32'(lsu_rsp_err), 32'(e.err));
         end
         lsu_rsp_rdy = 1'b1;
         tick();
         lsu_rsp_rdy = 1'b0;
         compare({tag, "_req_rdy_after"}, 32'(lsu_req_rdy), 32'd1);
         compare({tag, "_rsp_vld_after"}, 32'(lsu_rsp_vld), 32'd0);
      end
   endtask

   initial begin : stimulus
      int base_cnt;
      rst = 1'b1;
      lsu_req_vld = 1'b0; lsu_wen = 1'b0; lsu_rwtyp = 3'b010;
      lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_rsp_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      compare("rst_req_rdy", 32'(lsu_req_rdy), 32'd1);
      compare("rst_rsp_vld", 32'(lsu_rsp_vld), 32'd0);
      compare("rst_s_req_vld", 32'(s_req_vld), 32'd0);
      compare("rst_s_rsp_rdy", 32'(s_rsp_rdy), 32'd0);
      compare("rst_rdata", lsu_rsp_rdata, 32'd0);
      rst = 1'b0;
      tick();

      // Load word to slave 1, response two cycles after the slave handshake
      slv_lat = 2; slv_rdata = 32'hCAFE_F00D; base_cnt = req_count;
      applyStimulus(1'b0, RW_W, 32'h1000_0004, 32'h0, 32'hCAFE_F00D, 1'b0, 5);
      compare("t1_s_req_vld", 32'(s_req_vld), 32'h2);
      compare("t1_s_addr", s_addr, 32'h1000_0004);
      compare("t1_s_rwtyp", 32'(s_rwtyp), 32'h2);
      checkOutput("t1", 0);
      compare("t1_req_count", 32'(req_count - base_cnt), 32'd1);
      compare("t1_slave_sel", 32'(last_req_vld), 32'h2);

      // Store word to slave 0 with a zero-wait slave: data reads back as 0
      slv_lat = 1; slv_rdata = 32'h5555_AAAA; base_cnt = req_count;
      applyStimulus(1'b1, RW_W, 32'h0000_0008, 32'h0123_4567, 32'h0, 1'b0, 4);
      compare("st_s_wen", 32'(s_wen), 32'd1);
      compare("st_s_wdata", s_wdata, 32'h0123_4567);
      checkOutput("st", 0);
      compare("st_slave_sel", 32'(last_req_vld), 32'h1);

      // Misaligned halfword store
      base_cnt = req_count;
      applyStimulus(1'b1, RW_H, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
      checkOutput("t2", 0);
      // Unmapped address and illegal size code
      applyStimulus(1'b0, RW_W, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1);
      checkOutput("t3a", 0);
      applyStimulus(1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 1);
      checkOutput("t3b", 0);
      compare("t23_no_slave", 32'(req_count - base_cnt), 32'd0);

      // Timeout in WAIT: error after TMO cycles there, then a late stray pulse
      slv_lat = 0;
      applyStimulus(1'b0, RW_W, 32'h0000_0010, 32'h0, 32'h0, 1'b1, TMO + 2);
      checkOutput("t4", 0);
      pulse_req++;
      for (int i = 0; i < 3; i++) begin
         tick();
         compare("t4_stray_rsp_vld", 32'(lsu_rsp_vld), 32'd0);
         compare("t4_stray_req_rdy", 32'(lsu_req_rdy), 32'd1);
      end
      slv_lat = 1; slv_rdata = 32'h0BAD_CAFE;
      applyStimulus(1'b0, RW_W, 32'h1000_0000, 32'h0, 32'h0BAD_CAFE, 1'b0, 4);
      checkOutput("t4_next", 0);

      // Response held off by the LSU for five cycles
      slv_rdata = 32'h1234_5678;
      applyStimulus(1'b0, RW_HU, 32'h1000_0002, 32'h0, 32'h1234_5678, 1'b0, 4);
      checkOutput("t5", 5);

      // Reset in the middle of WAIT aborts the transaction
      slv_lat = 0;
      applyStimulus(1'b0, RW_W, 32'h1000_000C, 32'h0, 32'h0, 1'b1, 0);
      tick();
      compare("t6_in_wait", 32'(s_rsp_rdy), 32'h2);
      #2;
      rst = 1'b1;
      #1;
      compare("t6_req_rdy", 32'(lsu_req_rdy), 32'd1);
      compare("t6_rsp_vld", 32'(lsu_rsp_vld), 32'd0);
      compare("t6_s_rsp_rdy", 32'(s_rsp_rdy), 32'd0);
      compare("t6_s_req_vld", 32'(s_req_vld), 32'd0);
      compare("t6_s_addr", s_addr, 32'h0);
      tick();
      rst = 1'b0;
      void'(sb.pop_back());
      for (int i = 0; i < 3; i++) begin
         tick();
         compare("t6_no_rsp", 32'(lsu_rsp_vld), 32'd0);
      end
      slv_lat = 1; slv_rdata = 32'h7777_0001;
      applyStimulus(1'b0, RW_W, 32'h0000_0004, 32'h0, 32'h7777_0001, 1'b0, 4);
      checkOutput("t6_next", 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
